// File: rtl/cache_pkg.sv
// Shared types and helpers for the L1 miss/refill engine.
// Default geometry: 32-bit addresses, 32-bit words, 4-word lines.
package cache_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_WORDS  = 4;
  localparam int DEF_CNT_W  = 16;

  localparam int LINE_W = DEF_WORDS * DEF_DATA_W;
  localparam int OFF_W  = $clog2(DEF_WORDS * DEF_DATA_W / 8);
  localparam int IDX_W  = $clog2(DEF_WORDS);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WB      = 3'd1,
    RD_REQ  = 3'd2,
    RD_WAIT = 3'd3,
    FILL    = 3'd4
  } miss_state_t;

  // Clears the low off_w bits; callers widen/narrow around the 64-bit form.
  function automatic logic [63:0] line_align(input logic [63:0] addr, input int unsigned off_w);
    return addr & (~64'd0 << off_w);
  endfunction

endpackage

// File: rtl/cache_miss_handler.sv
// Miss handler: optional word-by-word victim writeback, word-by-word line
// refill from the next level, single-cycle line fill, saturating counters.
module cache_miss_handler
  import cache_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int WORDS  = DEF_WORDS,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      miss_valid,
  output logic                      miss_ready,
  input  logic [ADDR_W-1:0]         miss_addr,
  input  logic                      miss_dirty,
  input  logic [ADDR_W-1:0]         victim_addr,
  input  logic [WORDS*DATA_W-1:0]   victim_data,
  output logic                      fill_valid,
  output logic [ADDR_W-1:0]         fill_addr,
  output logic [WORDS*DATA_W-1:0]   fill_data,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic                      mem_req_we,
  output logic [ADDR_W-1:0]         mem_req_addr,
  output logic [DATA_W-1:0]         mem_req_wdata,
  input  logic                      mem_resp_valid,
  input  logic [DATA_W-1:0]         mem_resp_rdata,
  output logic                      busy,
  output logic [CNT_W-1:0]          miss_count,
  output logic [CNT_W-1:0]          wb_count
);

  localparam int BYTES     = DATA_W / 8;
  localparam int LINE_BITS = WORDS * DATA_W;
  localparam int OFF_BITS  = $clog2(WORDS * BYTES);
  localparam int IDX_BITS  = $clog2(WORDS);
  localparam logic [IDX_BITS-1:0] IDX_LAST = IDX_BITS'(WORDS - 1);
  localparam logic [CNT_W-1:0]    CNT_MAX  = {CNT_W{1'b1}};

  miss_state_t            state_q, state_d;
  logic [IDX_BITS-1:0]    idx_q, idx_d;
  logic [ADDR_W-1:0]      base_q, base_d;
  logic [ADDR_W-1:0]      vbase_q, vbase_d;
  logic [LINE_BITS-1:0]   victim_q, victim_d;
  logic [LINE_BITS-1:0]   line_q, line_d;
  logic [CNT_W-1:0]       miss_count_q, miss_count_d;
  logic [CNT_W-1:0]       wb_count_q, wb_count_d;
  logic [ADDR_W-1:0]      word_off_s;

  assign word_off_s = ADDR_W'(idx_q) * ADDR_W'(BYTES);

  // Next-state, index, line buffer and counter updates
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    base_d       = base_q;
    vbase_d      = vbase_q;
    victim_d     = victim_q;
    line_d       = line_q;
    miss_count_d = miss_count_q;
    wb_count_d   = wb_count_q;
    case (state_q)
      IDLE: begin
        if (miss_valid) begin
          base_d       = ADDR_W'(line_align(64'(miss_addr), OFF_BITS));
          vbase_d      = ADDR_W'(line_align(64'(victim_addr), OFF_BITS));
          victim_d     = victim_data;
          idx_d        = '0;
          state_d      = miss_dirty ? WB : RD_REQ;
          miss_count_d = (miss_count_q == CNT_MAX) ? miss_count_q : miss_count_q + CNT_W'(1);
          if (miss_dirty) begin
            wb_count_d = (wb_count_q == CNT_MAX) ? wb_count_q : wb_count_q + CNT_W'(1);
          end else begin
            wb_count_d = wb_count_q;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WB: begin
        if (mem_req_ready) begin
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = RD_REQ;
          end else begin
            idx_d = idx_q + IDX_BITS'(1);
          end
        end else begin
          state_d = WB;
        end
      end
      RD_REQ: begin
        if (mem_req_ready) begin
          state_d = RD_WAIT;
        end else begin
          state_d = RD_REQ;
        end
      end
      RD_WAIT: begin
        if (mem_resp_valid) begin
          line_d[int'(idx_q)*DATA_W +: DATA_W] = mem_resp_rdata;
          if (idx_q == IDX_LAST) begin
            state_d = FILL;
          end else begin
            idx_d   = idx_q + IDX_BITS'(1);
            state_d = RD_REQ;
          end
        end else begin
          state_d = RD_WAIT;
        end
      end
      FILL: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode from registered state only; bus fields are zero when idle
  always_comb begin
    mem_req_valid = 1'b0;
    mem_req_we    = 1'b0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    fill_valid    = 1'b0;
    fill_addr     = '0;
    fill_data     = '0;
    case (state_q)
      WB: begin
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        mem_req_addr  = vbase_q + word_off_s;
        mem_req_wdata = victim_q[int'(idx_q)*DATA_W +: DATA_W];
      end
      RD_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = base_q + word_off_s;
      end
      FILL: begin
        fill_valid = 1'b1;
        fill_addr  = base_q;
        fill_data  = line_q;
      end
      default: begin
        mem_req_valid = 1'b0;
      end
    endcase
  end

  assign miss_ready = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign miss_count = miss_count_q;
  assign wb_count   = wb_count_q;

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      base_q       <= '0;
      vbase_q      <= '0;
      victim_q     <= '0;
      line_q       <= '0;
      miss_count_q <= '0;
      wb_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      base_q       <= base_d;
      vbase_q      <= vbase_d;
      victim_q     <= victim_d;
      line_q       <= line_d;
      miss_count_q <= miss_count_d;
      wb_count_q   <= wb_count_d;
    end
  end

endmodule

// File: tb/tb_cache_miss_handler.sv
// Self-checking bench for cache_miss_handler: memory responder, bus monitor,
// and a line-level reference model of refill/writeback behaviour.
module tb_cache_miss_handler;

  localparam int WORDS = 4;

  logic         clk, reset;
  logic         miss_valid, miss_ready, miss_dirty;
  logic [31:0]  miss_addr, victim_addr;
  logic [127:0] victim_data, fill_data;
  logic         fill_valid;
  logic [31:0]  fill_addr;
  logic         mem_req_valid, mem_req_ready, mem_req_we;
  logic [31:0]  mem_req_addr, mem_req_wdata;
  logic         mem_resp_valid;
  logic [31:0]  mem_resp_rdata;
  logic         busy;
  logic [15:0]  miss_count, wb_count;

  int n_checks = 0;
  int n_errors = 0;
  int cyc;
  int n_resp;
  int resp_limit = 1000000;
  int stall_from = 0;
  int stall_len  = 0;
  int spur_cyc   = -1;
  int n_req, n_fill, n_stall, bad_idle;
  int exp_miss = 0;
  int exp_wb   = 0;

  logic [31:0]  pre_mem [logic [31:0]];
  logic [31:0]  wr_mem  [logic [31:0]];
  logic         req_we_a   [512];
  logic [31:0]  req_addr_a [512];
  logic [31:0]  req_data_a [512];
  int           fill_cyc_a [64];
  logic [31:0]  fill_addr_a[64];
  logic [127:0] fill_data_a[64];
  logic [31:0]  stall_addr_a[64];

  cache_miss_handler dut (
    .clk(clk), .reset(reset),
    .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr),
    .miss_dirty(miss_dirty), .victim_addr(victim_addr), .victim_data(victim_data),
    .fill_valid(fill_valid), .fill_addr(fill_addr), .fill_data(fill_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .busy(busy), .miss_count(miss_count), .wb_count(wb_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (wr_mem.exists(a)) return wr_mem[a];
    else if (pre_mem.exists(a)) return pre_mem[a];
    else return a ^ 32'hC0DE_0000;
  endfunction

  // Line the cache should receive: victim words if the victim is the same line, else memory
  function automatic logic [127:0] model_line(input logic [31:0] addr, input logic dirty,
                                              input logic [31:0] vaddr, input logic [127:0] vdata);
    logic [31:0]  base, vbase;
    logic [127:0] l;
    base  = addr - (addr % 32'd16);
    vbase = vaddr - (vaddr % 32'd16);
    for (int i = 0; i < WORDS; i++)
      l[i*32 +: 32] = (dirty && base == vbase) ? vdata[i*32 +: 32] : mem_rd(base + 32'(4*i));
    return l;
  endfunction

  // Memory: configurable stalls, reads answered in the cycle after acceptance
  initial begin : responder
    logic        rd_fire;
    logic [31:0] rd_addr;
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = 32'd0;
    cyc    = 0;
    n_resp = 0;
    forever begin
      @(negedge clk);
      rd_fire = mem_req_valid && mem_req_ready && !mem_req_we && !reset;
      rd_addr = mem_req_addr;
      if (mem_req_valid && mem_req_ready && mem_req_we && !reset) wr_mem[mem_req_addr] = mem_req_wdata;
      @(posedge clk);
      cyc++;
      #1;
      mem_req_ready = !(cyc >= stall_from && cyc < stall_from + stall_len);
      if (rd_fire && n_resp < resp_limit) begin
        mem_resp_valid = 1'b1;
        mem_resp_rdata = mem_rd(rd_addr);
        n_resp++;
      end else if (cyc == spur_cyc) begin
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'hDEAD_BEEF;
      end else begin
        mem_resp_valid = 1'b0;
        mem_resp_rdata = 32'd0;
      end
    end
  end

  initial begin : monitor
    n_req = 0; n_fill = 0; n_stall = 0; bad_idle = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (mem_req_valid && mem_req_ready) begin
          req_we_a[n_req] = mem_req_we; req_addr_a[n_req] = mem_req_addr; req_data_a[n_req] = mem_req_wdata;
          n_req++;
        end
        if (mem_req_valid && !mem_req_ready) begin
          stall_addr_a[n_stall] = mem_req_addr;
          n_stall++;
        end
        if (!mem_req_valid && (mem_req_we || mem_req_addr != 32'd0 || mem_req_wdata != 32'd0)) bad_idle++;
        if (fill_valid) begin
          fill_cyc_a[n_fill] = cyc; fill_addr_a[n_fill] = fill_addr; fill_data_a[n_fill] = fill_data;
          n_fill++;
        end
      end
    end
  end

  task automatic run_miss(input logic [31:0] addr, input logic dirty, input logic [31:0] vaddr,
                          input logic [127:0] vdata, output int acc);
    @(posedge clk); #2;
    miss_addr = addr; miss_dirty = dirty; victim_addr = vaddr; victim_data = vdata;
    miss_valid = 1'b1;
    acc = -1;
    for (int k = 0; k < 100; k++) begin
      if (miss_ready) begin
        @(posedge clk); #2;
        acc = cyc;
        break;
      end
      @(posedge clk); #2;
    end
    miss_valid = 1'b0;
    if (acc >= 0) begin
      exp_miss = (exp_miss == 65535) ? 65535 : exp_miss + 1;
      if (dirty) exp_wb = (exp_wb == 65535) ? 65535 : exp_wb + 1;
    end
  endtask

  task automatic wait_fills(input int target, output logic ok);
    for (int k = 0; k < 100; k++) begin
      if (n_fill >= target) break;
      @(posedge clk); #2;
    end
    ok = (n_fill >= target);
  endtask

  task automatic test_reset();
    n_checks++; if (miss_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready: got %b want 1", miss_ready); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if ({mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata} !== 66'd0) begin
      n_errors++; $display("FAIL reset_mem_req: got v=%b a=%h want all zero", mem_req_valid, mem_req_addr); end
    n_checks++; if ({fill_valid, fill_addr, fill_data} !== 161'd0) begin
      n_errors++; $display("FAIL reset_fill: got v=%b a=%h want all zero", fill_valid, fill_addr); end
    n_checks++; if ({miss_count, wb_count} !== 32'd0) begin
      n_errors++; $display("FAIL reset_counters: got %h/%h want 0/0", miss_count, wb_count); end
  endtask

  task automatic test_clean_miss();
    int acc, n0, f0;
    logic ok;
    for (int i = 0; i < WORDS; i++) pre_mem[32'h47A40 + 32'(4*i)] = 32'hA0 + 32'(i);
    n0 = n_req; f0 = n_fill;
    run_miss(32'h47A48, 1'b0, 32'h0, 128'd0, acc);
    wait_fills(f0 + 1, ok);
    n_checks++; if (!ok || acc < 0) begin n_errors++; $display("FAIL clean_done: got ok=%b acc=%0d want fill", ok, acc); end
    n_checks++; if (n_req - n0 !== 4) begin n_errors++; $display("FAIL clean_nreq: got %0d want 4", n_req - n0); end
    for (int i = 0; i < WORDS; i++) begin
      n_checks++;
      if (req_we_a[n0+i] !== 1'b0 || req_addr_a[n0+i] !== 32'h47A40 + 32'(4*i)) begin
        n_errors++; $display("FAIL clean_rd%0d: got we=%b a=%h want we=0 a=%h", i, req_we_a[n0+i],
                             req_addr_a[n0+i], 32'h47A40 + 32'(4*i)); end
    end
    n_checks++; if (fill_cyc_a[f0] - acc + 1 !== 9) begin
      n_errors++; $display("FAIL clean_latency: got %0d want 9", fill_cyc_a[f0] - acc + 1); end
    n_checks++; if (fill_addr_a[f0] !== 32'h47A40) begin
      n_errors++; $display("FAIL clean_fill_addr: got %h want 47a40", fill_addr_a[f0]); end
    n_checks++; if (fill_data_a[f0] !== 128'h000000A3_000000A2_000000A1_000000A0) begin
      n_errors++; $display("FAIL clean_fill_data: got %h want a3a2a1a0", fill_data_a[f0]); end
    repeat (3) begin @(posedge clk); #2; end
    n_checks++; if (n_fill - f0 !== 1) begin n_errors++; $display("FAIL clean_one_pulse: got %0d fills want 1", n_fill - f0); end
    n_checks++; if (miss_count !== 16'(exp_miss) || wb_count !== 16'(exp_wb)) begin
      n_errors++; $display("FAIL clean_counters: got %0d/%0d want %0d/%0d", miss_count, wb_count, exp_miss, exp_wb); end
  endtask

  task automatic test_dirty_miss();
    int acc, n0, f0;
    logic ok;
    logic [31:0]  addr;
    logic [127:0] vdata, exp;
    for (int i = 0; i < WORDS; i++) vdata[i*32 +: 32] = 32'h333333 + 32'(i);
    addr = $urandom;
    exp  = model_line(addr, 1'b1, 32'hCA55C, vdata);
    n0 = n_req; f0 = n_fill;
    run_miss(addr, 1'b1, 32'hCA55C, vdata, acc);
    wait_fills(f0 + 1, ok);
    n_checks++; if (!ok || n_req - n0 !== 8) begin n_errors++; $display("FAIL dirty_nreq: got ok=%b n=%0d want 8", ok, n_req - n0); end
    for (int i = 0; i < WORDS; i++) begin
      n_checks++;
      if (req_we_a[n0+i] !== 1'b1 || req_addr_a[n0+i] !== 32'hCA550 + 32'(4*i) || req_data_a[n0+i] !== 32'h333333 + 32'(i)) begin
        n_errors++; $display("FAIL dirty_wr%0d: got we=%b a=%h d=%h want we=1 a=%h d=%h", i, req_we_a[n0+i],
                             req_addr_a[n0+i], req_data_a[n0+i], 32'hCA550 + 32'(4*i), 32'h333333 + 32'(i)); end
      n_checks++;
      if (req_we_a[n0+4+i] !== 1'b0 || req_addr_a[n0+4+i] !== (addr & 32'hFFFF_FFF0) + 32'(4*i)) begin
        n_errors++; $display("FAIL dirty_rd%0d: got we=%b a=%h want we=0 a=%h", i, req_we_a[n0+4+i],
                             req_addr_a[n0+4+i], (addr & 32'hFFFF_FFF0) + 32'(4*i)); end
    end
    n_checks++; if (fill_cyc_a[f0] - acc + 1 !== 13) begin
      n_errors++; $display("FAIL dirty_latency: got %0d want 13", fill_cyc_a[f0] - acc + 1); end
    n_checks++; if (fill_data_a[f0] !== exp) begin n_errors++; $display("FAIL dirty_fill_data: got %h want %h", fill_data_a[f0], exp); end
    n_checks++; if (wb_count !== 16'(exp_wb) || miss_count !== 16'(exp_miss)) begin
      n_errors++; $display("FAIL dirty_counters: got %0d/%0d want %0d/%0d", miss_count, wb_count, exp_miss, exp_wb); end
  endtask

  task automatic test_stall();
    int acc, n0, f0, s0;
    logic ok;
    n0 = n_req; f0 = n_fill; s0 = n_stall;
    run_miss(32'h47A48, 1'b0, 32'h0, 128'd0, acc);
    stall_from = acc + 4; stall_len = 3; spur_cyc = acc + 4;
    wait_fills(f0 + 1, ok);
    stall_len = 0; spur_cyc = -1;
    n_checks++; if (!ok || n_stall - s0 !== 3) begin n_errors++; $display("FAIL stall_cycles: got ok=%b n=%0d want 3", ok, n_stall - s0); end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (stall_addr_a[s0+i] !== 32'h47A48) begin
        n_errors++; $display("FAIL stall_hold%0d: got %h want 47a48", i, stall_addr_a[s0+i]); end
    end
    n_checks++; if (n_req - n0 !== 4 || req_addr_a[n0+2] !== 32'h47A48) begin
      n_errors++; $display("FAIL stall_reqs: got n=%0d a2=%h want 4/47a48", n_req - n0, req_addr_a[n0+2]); end
    n_checks++; if (fill_cyc_a[f0] - acc + 1 !== 12) begin
      n_errors++; $display("FAIL stall_latency: got %0d want 12", fill_cyc_a[f0] - acc + 1); end
    n_checks++; if (fill_data_a[f0] !== 128'h000000A3_000000A2_000000A1_000000A0) begin
      n_errors++; $display("FAIL stall_fill_data: got %h want a3a2a1a0", fill_data_a[f0]); end
  endtask

  task automatic test_reset_midflight();
    int acc, n0, f0;
    resp_limit = n_resp + 1;
    run_miss($urandom, 1'b0, 32'h0, 128'd0, acc);
    repeat (4) begin @(posedge clk); #2; end
    #1 reset = 1'b1;
    #1;
    exp_miss = 0; exp_wb = 0;
    n_checks++; if (miss_ready !== 1'b1 || busy !== 1'b0) begin
      n_errors++; $display("FAIL midrst_state: got ready=%b busy=%b want 1/0", miss_ready, busy); end
    n_checks++; if ({mem_req_valid, mem_req_we, mem_req_addr, fill_valid, fill_addr} !== 67'd0) begin
      n_errors++; $display("FAIL midrst_outputs: got v=%b a=%h fv=%b want zero", mem_req_valid, mem_req_addr, fill_valid); end
    n_checks++; if ({miss_count, wb_count} !== 32'd0) begin
      n_errors++; $display("FAIL midrst_counters: got %h/%h want 0/0", miss_count, wb_count); end
    @(negedge clk);
    reset = 1'b0;
    resp_limit = 1000000;
    spur_cyc = cyc + 1;
    n0 = n_req; f0 = n_fill;
    repeat (20) begin @(posedge clk); #2; end
    spur_cyc = -1;
    n_checks++; if (n_fill !== f0 || n_req !== n0 || busy !== 1'b0) begin
      n_errors++; $display("FAIL midrst_late_resp: got fills=%0d reqs=%0d busy=%b want 0/0/0", n_fill - f0, n_req - n0, busy); end
  endtask

  task automatic test_back_to_back();
    int acc1, acc2, f0;
    logic ok;
    logic [127:0] exp1, exp2;
    exp1 = model_line(32'h5064D, 1'b0, 32'h0, 128'd0);
    exp2 = model_line(32'h2E47F, 1'b0, 32'h0, 128'd0);
    f0 = n_fill;
    acc1 = -1; acc2 = -1;
    @(posedge clk); #2;
    miss_addr = 32'h5064D; miss_dirty = 1'b0; victim_addr = 32'h0; victim_data = 128'd0; miss_valid = 1'b1;
    for (int k = 0; k < 60; k++) begin
      if (miss_ready) begin @(posedge clk); #2; acc1 = cyc; break; end
      @(posedge clk); #2;
    end
    miss_addr = 32'h2E47F;
    for (int k = 0; k < 60; k++) begin
      if (miss_ready) begin @(posedge clk); #2; acc2 = cyc; break; end
      @(posedge clk); #2;
    end
    miss_valid = 1'b0;
    if (acc1 >= 0) exp_miss++;
    if (acc2 >= 0) exp_miss++;
    wait_fills(f0 + 2, ok);
    n_checks++; if (!ok || acc1 < 0 || acc2 < 0) begin n_errors++; $display("FAIL b2b_done: got ok=%b acc=%0d/%0d want two fills", ok, acc1, acc2); end
    n_checks++; if (acc2 !== fill_cyc_a[f0] + 2) begin
      n_errors++; $display("FAIL b2b_reaccept: got cycle %0d want %0d", acc2, fill_cyc_a[f0] + 2); end
    n_checks++; if (fill_addr_a[f0] !== 32'h50640 || fill_addr_a[f0+1] !== 32'h2E470) begin
      n_errors++; $display("FAIL b2b_fill_addr: got %h/%h want 50640/2e470", fill_addr_a[f0], fill_addr_a[f0+1]); end
    n_checks++; if (fill_data_a[f0] !== exp1 || fill_data_a[f0+1] !== exp2) begin
      n_errors++; $display("FAIL b2b_fill_data: got %h/%h want %h/%h", fill_data_a[f0], fill_data_a[f0+1], exp1, exp2); end
    n_checks++; if (fill_cyc_a[f0+1] - acc2 + 1 !== 9) begin
      n_errors++; $display("FAIL b2b_latency2: got %0d want 9", fill_cyc_a[f0+1] - acc2 + 1); end
    n_checks++; if (miss_count !== 16'(exp_miss)) begin n_errors++; $display("FAIL b2b_miss_count: got %0d want %0d", miss_count, exp_miss); end
  endtask

  task automatic test_saturate();
    int acc, f0;
    logic ok;
    @(posedge clk); #2;
    force dut.miss_count_q = 16'hFFFF;
    @(posedge clk); #2;
    release dut.miss_count_q;
    exp_miss = 65535;
    f0 = n_fill;
    run_miss($urandom, 1'b1, $urandom, {$urandom, $urandom, $urandom, $urandom}, acc);
    wait_fills(f0 + 1, ok);
    n_checks++; if (!ok || miss_count !== 16'hFFFF) begin n_errors++; $display("FAIL sat_miss_count: got %h want ffff", miss_count); end
    n_checks++; if (wb_count !== 16'(exp_wb)) begin n_errors++; $display("FAIL sat_wb_count: got %0d want %0d", wb_count, exp_wb); end
  endtask

  task automatic test_random();
    int acc, n0, f0, nw;
    logic ok, dirty;
    logic [31:0]  addr, vaddr, base, vbase;
    logic [127:0] vdata, exp;
    for (int t = 0; t < 8; t++) begin
      addr  = $urandom;
      dirty = 1'($urandom_range(0, 1));
      vaddr = ($urandom_range(0, 3) == 0) ? addr ^ 32'(($urandom_range(0, 15))) : $urandom;
      vdata = {$urandom, $urandom, $urandom, $urandom};
      base  = addr - (addr % 32'd16);
      vbase = vaddr - (vaddr % 32'd16);
      exp   = model_line(addr, dirty, vaddr, vdata);
      nw    = dirty ? WORDS : 0;
      n0 = n_req; f0 = n_fill;
      run_miss(addr, dirty, vaddr, vdata, acc);
      wait_fills(f0 + 1, ok);
      n_checks++; if (!ok || n_req - n0 !== nw + WORDS) begin
        n_errors++; $display("FAIL rand%0d_nreq: got ok=%b n=%0d want %0d", t, ok, n_req - n0, nw + WORDS); end
      for (int i = 0; i < nw + WORDS; i++) begin
        n_checks++;
        if (i < nw) begin
          if (req_we_a[n0+i] !== 1'b1 || req_addr_a[n0+i] !== vbase + 32'(4*i) || req_data_a[n0+i] !== vdata[i*32 +: 32]) begin
            n_errors++; $display("FAIL rand%0d_wr%0d: got a=%h d=%h want a=%h d=%h", t, i, req_addr_a[n0+i],
                                 req_data_a[n0+i], vbase + 32'(4*i), vdata[i*32 +: 32]); end
        end else begin
          if (req_we_a[n0+i] !== 1'b0 || req_addr_a[n0+i] !== base + 32'(4*(i-nw))) begin
            n_errors++; $display("FAIL rand%0d_rd%0d: got we=%b a=%h want a=%h", t, i, req_we_a[n0+i],
                                 req_addr_a[n0+i], base + 32'(4*(i-nw))); end
        end
      end
      n_checks++; if (fill_addr_a[f0] !== base || fill_data_a[f0] !== exp) begin
        n_errors++; $display("FAIL rand%0d_fill: got %h:%h want %h:%h", t, fill_addr_a[f0], fill_data_a[f0], base, exp); end
      n_checks++; if (fill_cyc_a[f0] - acc + 1 !== (dirty ? 13 : 9)) begin
        n_errors++; $display("FAIL rand%0d_latency: got %0d want %0d", t, fill_cyc_a[f0] - acc + 1, dirty ? 13 : 9); end
      n_checks++; if (miss_count !== 16'(exp_miss) || wb_count !== 16'(exp_wb)) begin
        n_errors++; $display("FAIL rand%0d_counters: got %0d/%0d want %0d/%0d", t, miss_count, wb_count, exp_miss, exp_wb); end
    end
    n_checks++; if (bad_idle !== 0) begin n_errors++; $display("FAIL idle_bus_zero: got %0d nonzero cycles want 0", bad_idle); end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    reset = 1'b1; miss_valid = 1'b0; miss_dirty = 1'b0;
    miss_addr = 32'd0; victim_addr = 32'd0; victim_data = 128'd0;
    repeat (3) @(posedge clk);
    #2;
    test_reset();
    @(negedge clk);
    reset = 1'b0;
    test_clean_miss();
    test_dirty_miss();
    test_stall();
    test_reset_midflight();
    test_back_to_back();
    test_random();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cache_miss_handler.md
# cache_miss_handler

Refill/writeback engine directly downstream of the L1 `cache`. On a miss it accepts one request, writes back the dirty victim line word by word if required, fetches the missing line word by word from the next level (L2 or main memory), and returns the assembled line to the cache in a single-cycle fill. It also keeps the miss and writeback counters reported alongside the cache's performance summary.

## Interface
- `ADDR_W`, 32: byte-address width.
- `DATA_W`, 32: word width; addresses step by `DATA_W/8`.
- `WORDS`, 4: words per line; power of two, at least 2.
- `CNT_W`, 16: width of the performance counters.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `miss_valid` in 1: a miss request is presented.
- `miss_ready` out 1: the handler can accept a request.
- `miss_addr` in ADDR_W: missing byte address; any offset is allowed.
- `miss_dirty` in 1: the victim must be written back.
- `victim_addr` in ADDR_W: victim line address; offset bits are ignored.
- `victim_data` in WORDS*DATA_W: victim line; word i is at bits [i*DATA_W +: DATA_W].
- `fill_valid` out 1: one-cycle pulse carrying the refilled line.
- `fill_addr` out ADDR_W: line-aligned address of the fill.
- `fill_data` out WORDS*DATA_W: refilled line, same word packing as `victim_data`.
- `mem_req_valid` out 1: memory request is valid.
- `mem_req_ready` in 1: memory accepts the request.
- `mem_req_we` out 1: 1 means write, 0 means read.
- `mem_req_addr` out ADDR_W: word-aligned memory address.
- `mem_req_wdata` out DATA_W: write data.
- `mem_resp_valid` in 1: read data is valid; responses return in order.
- `mem_resp_rdata` in DATA_W: read data.
- `busy` out 1: high in any state other than IDLE.
- `miss_count` out CNT_W: number of accepted misses.
- `wb_count` out CNT_W: number of accepted dirty misses.

## Operation
- States: IDLE, WB, RD_REQ, RD_WAIT, FILL.
- IDLE: `miss_ready=1`. On `miss_valid && miss_ready` the handler:
  - latches the line base of `miss_addr`, which is `miss_addr` with its low log2(WORDS*DATA_W/8) bits cleared;
  - latches `victim_addr` aligned the same way, and `victim_data`;
  - clears the word index;
  - moves to WB if `miss_dirty` is set, otherwise to RD_REQ.
- WB: drives `mem_req_valid=1`, `we=1`, `addr=vbase+idx*DATA_W/8`, `wdata=victim word idx`.
  - Each beat completes on `mem_req_valid && mem_req_ready`, and the index increments.
  - After beat WORDS-1, the index clears and the state moves to RD_REQ.
  - Writes produce no response.
- RD_REQ: drives `mem_req_valid=1`, `we=0`, `addr=base+idx*DATA_W/8`. On acceptance, moves to RD_WAIT.
- RD_WAIT: `mem_req_valid=0`. On `mem_resp_valid`, the data is stored in word idx.
  - If idx is WORDS-1, move to FILL.
  - Otherwise increment idx and return to RD_REQ.
- FILL: `fill_valid=1` for exactly one cycle with `fill_addr=base` and the assembled line, then return to IDLE.
- `mem_resp_valid` outside RD_WAIT is ignored.
- `mem_req_addr`, `mem_req_we` and `mem_req_wdata` are 0 whenever `mem_req_valid=0`.
- Counters increment on acceptance: `miss_count` for every miss, `wb_count` additionally when `miss_dirty` is set. Both saturate at all-ones and never wrap.
- Address arithmetic is modulo 2^ADDR_W. Offset bits are never carried into the tag.
- Reset (asynchronous, including mid-operation):
  - state goes to IDLE;
  - all outputs go to 0 except `miss_ready`, which is 1;
  - counters, index and line buffer are cleared;
  - any in-flight transfer is abandoned, and a response arriving after reset is ignored.

## Timing
- Cycle 0 is the accepting edge. The first memory request is valid in cycle 1.
- Latency with no backpressure and read responses in the cycle after acceptance:
  - clean miss: `fill_valid` in cycle 1+2*WORDS, which is 9 for WORDS=4;
  - dirty miss: `fill_valid` in cycle 1+3*WORDS, which is 13 for WORDS=4.
- While `mem_req_ready=0`, all `mem_req_*` signals hold stable.
- `miss_ready` rises in the cycle after FILL. A new miss can therefore be accepted at the earliest 1 cycle after `fill_valid`.
- Outputs are registered or decoded from state only. There is no combinational path from `mem_resp_*` to `mem_req_*`.

## Structure
- Package `cache_pkg` holds:
  - the `miss_state_t` enum (IDLE, WB, RD_REQ, RD_WAIT, FILL);
  - localparams `LINE_W=WORDS*DATA_W`, `OFF_W=$clog2(WORDS*DATA_W/8)` and `IDX_W=$clog2(WORDS)`;
  - an address-alignment function.
- There is no sub-module. The FSM, index, line buffer and saturating counters are implemented inline in `cache_miss_handler`.

## Test plan
- Clean miss, `miss_addr=0x47A48`, ready=1, responses next cycle, data 0xA0..0xA3 -> reads issued to 0x47A40, 0x47A44, 0x47A48, 0x47A4C; `fill_valid` in cycle 9 with `fill_addr=0x47A40` and `fill_data={0xA3,0xA2,0xA1,0xA0}`; `miss_count=1`.
- Dirty miss, `victim_addr=0xCA55C`, `victim_data` words 0x333333+i -> writes to 0xCA550..0xCA55C with those words in order, then the line reads; fill in cycle 13; `wb_count=1`.
- `mem_req_ready` low for 3 cycles on read beat 2 -> address 0x47A48 held stable; fill delayed by exactly 3 cycles; the spurious `mem_resp_valid` pulse in RD_REQ is ignored.
- Reset asserted in RD_WAIT of beat 1, then a late response arrives -> outputs zero, `miss_ready=1`, counters 0; no `fill_valid` is generated.
- Back-to-back misses 0x5064D then 0x2E47F with `miss_valid` held high -> the second is accepted 1 cycle after the first fill; fills at 0x50640 and 0x2E470; `miss_count=2`.
- Counter preloaded via force to 0xFFFF, then one miss -> `miss_count` stays 0xFFFF.
